// File: rtl/router_sync_n.sv
// Address latch, FIFO write steering and stalled-FIFO supervision for an N-port router.
// Latency: write_enb/fifo_full/vld_out combinational; addr_err, soft_reset, timeout_status one edge.
// Backpressure: none consumed here; fifo_full reflects the addressed FIFO so the FSM can stall.
module router_sync_n #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30,
    parameter int CNT_W     = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 detec_addr,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic                 status_clr,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err,
    output logic [NUM_PORTS-1:0] timeout_status
);

    // One extra bit so NUM_PORTS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  NUM_PORTS_W = (ADDR_W+1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 addr_err_q, addr_err_d;
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] soft_reset_q, soft_reset_d;
    logic [NUM_PORTS-1:0] timeout_status_q, timeout_status_d;

    logic                 addr_valid;
    logic [NUM_PORTS-1:0] port_sel;
    logic [NUM_PORTS-1:0] stalled;

    // Decode the latched address; an out-of-range address selects no port at all.
    always_comb begin
        addr_valid = ({1'b0, addr_q} < NUM_PORTS_W);
        port_sel   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_sel[i] = addr_valid && (addr_q == ADDR_W'(i));
        end
        write_enb = write_enb_reg ? port_sel : '0;
        fifo_full = |(full & port_sel);
        vld_out   = ~empty;
        stalled   = ~empty & ~read_enb;
    end

    // Next-state: header address capture and per-port stall timeout counters.
    always_comb begin
        addr_d           = addr_q;
        addr_err_d       = addr_err_q;
        cnt_d            = cnt_q;
        soft_reset_d     = '0;
        timeout_status_d = timeout_status_q;

        if (detec_addr) begin
            addr_d     = data_in;
            addr_err_d = ({1'b0, data_in} >= NUM_PORTS_W);
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!stalled[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]        = '0;
                soft_reset_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // A new timeout outranks a simultaneous software clear.
            if (soft_reset_d[i]) begin
                timeout_status_d[i] = 1'b1;
            end else if (status_clr) begin
                timeout_status_d[i] = 1'b0;
            end
        end
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q           <= '0;
            addr_err_q       <= 1'b0;
            soft_reset_q     <= '0;
            timeout_status_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            addr_q           <= addr_d;
            addr_err_q       <= addr_err_d;
            soft_reset_q     <= soft_reset_d;
            timeout_status_q <= timeout_status_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign soft_reset     = soft_reset_q;
    assign addr_err       = addr_err_q;
    assign timeout_status = timeout_status_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: directed scenarios followed by random traffic.
// Expected outputs come from a stall-run-length model and are checked by a separate monitor.
// Inputs change on the falling edge; the monitor samples 3 ns later, well clear of the rising edge.
module tb_router_sync_n;

    localparam int NP      = 3;
    localparam int AW      = 2;
    localparam int TIMEOUT = 30;

    logic          clock;
    logic          reset;
    logic          detec_addr;
    logic [AW-1:0] data_in;
    logic          write_enb_reg;
    logic [NP-1:0] read_enb, full, empty;
    logic          status_clr;
    logic [NP-1:0] write_enb, vld_out, soft_reset, timeout_status;
    logic          fifo_full, addr_err;

    router_sync_n #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .detec_addr(detec_addr), .data_in(data_in),
        .write_enb_reg(write_enb_reg), .read_enb(read_enb), .full(full), .empty(empty),
        .status_clr(status_clr), .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out(vld_out), .soft_reset(soft_reset), .addr_err(addr_err),
        .timeout_status(timeout_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [NP-1:0] we;
        logic          ff;
        logic [NP-1:0] vld;
        logic [NP-1:0] sr;
        logic          ae;
        logic [NP-1:0] ts;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model state: latched address, and per-port length of the current stall run.
    int          m_addr = 0;
    bit          m_ae   = 0;
    int          run [NP];
    bit [NP-1:0] m_sr = '0;
    bit [NP-1:0] m_ts = '0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // One clock cycle of stimulus: drive, record what the outputs must be, then advance the model.
    task automatic step(input bit rst, input bit det, input logic [AW-1:0] din, input bit wer,
                        input logic [NP-1:0] rd, input logic [NP-1:0] fl,
                        input logic [NP-1:0] em, input bit clr);
        exp_t        e;
        bit [NP-1:0] nsr;
        @(negedge clock);
        reset = rst; detec_addr = det; data_in = din; write_enb_reg = wer;
        read_enb = rd; full = fl; empty = em; status_clr = clr;
        if (!rst) begin
            m_addr = 0; m_ae = 0; m_sr = '0; m_ts = '0;
            for (int i = 0; i < NP; i++) run[i] = 0;
        end
        e.we  = (wer && m_addr < NP) ? NP'(1 << m_addr) : '0;
        e.ff  = (m_addr < NP) ? fl[m_addr] : 1'b0;
        e.vld = ~em;
        e.sr  = m_sr;
        e.ae  = m_ae;
        e.ts  = m_ts;
        exp_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                if (!em[i] && !rd[i]) begin
                    run[i] = run[i] + 1;
                    nsr[i] = (run[i] % TIMEOUT) == 0;
                end else begin
                    run[i] = 0;
                    nsr[i] = 1'b0;
                end
                if (nsr[i]) m_ts[i] = 1'b1;
                else if (clr) m_ts[i] = 1'b0;
            end
            m_sr = nsr;
            if (det) begin
                m_addr = int'(din);
                m_ae   = int'(din) >= NP;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, '0, '0, '1, 0);
    endtask

    task automatic stall(input int n, input logic [NP-1:0] em, input logic [NP-1:0] rd, input bit clr);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, rd, '0, em, clr);
    endtask

    // Monitor: pops one expectation per cycle and compares every output against it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write_enb",      8'(write_enb),      8'(e.we));
                chk("fifo_full",      8'(fifo_full),      8'(e.ff));
                chk("vld_out",        8'(vld_out),        8'(e.vld));
                chk("soft_reset",     8'(soft_reset),     8'(e.sr));
                chk("addr_err",       8'(addr_err),       8'(e.ae));
                chk("timeout_status", 8'(timeout_status), 8'(e.ts));
            end
        end
    end

    initial begin
        for (int i = 0; i < NP; i++) run[i] = 0;
        reset = 0; detec_addr = 0; data_in = '0; write_enb_reg = 0;
        read_enb = '0; full = '0; empty = '1; status_clr = 0;

        // Reset state, including write_enb_reg asserted while in reset.
        step(0, 0, 0, 0, '0, '0, '1, 0);
        step(0, 0, 0, 1, '0, '1, '1, 0);
        idle(1);

        // Valid address 2: write steering and full passthrough.
        step(1, 1, 2, 0, '0, '0, '1, 0);
        step(1, 0, 0, 1, '0, 3'b100, '1, 0);
        step(1, 0, 0, 1, '0, 3'b011, '1, 0);

        // Out-of-range address 3: no write, fifo_full masked, addr_err set then cleared.
        step(1, 1, 3, 0, '0, '0, '1, 0);
        step(1, 0, 0, 1, '0, 3'b111, '1, 0);
        step(1, 1, 0, 0, '0, '0, '1, 0);
        step(1, 0, 0, 1, '0, 3'b001, '1, 0);

        // Header and write on the same edge: old address is used this cycle.
        step(1, 1, 1, 1, '0, '0, '1, 0);
        step(1, 0, 0, 1, '0, 3'b010, '1, 0);
        idle(2);

        // Port 1 stalled for two full timeout periods: two pulses, other ports quiet.
        stall(2 * TIMEOUT + 2, 3'b101, '0, 0);
        idle(2);

        // Port 0: a single read restarts the count.
        stall(TIMEOUT - 1, 3'b110, '0, 0);
        stall(1, 3'b110, 3'b001, 0);
        stall(TIMEOUT - 1, 3'b110, '0, 0);
        stall(2, 3'b110, '0, 0);
        idle(2);

        // Port 2: clear on the same edge as the timeout loses; a later clear wins.
        stall(TIMEOUT - 1, 3'b011, '0, 0);
        stall(1, 3'b011, '0, 1);
        idle(2);
        step(1, 0, 0, 0, '0, '0, '1, 1);
        idle(1);

        // Reset asserted mid-stall clears everything without a clock edge.
        step(1, 1, 2, 0, '0, '0, '1, 0);
        stall(20, 3'b110, '0, 0);
        step(0, 0, 0, 1, '0, '1, 3'b110, 0);
        stall(TIMEOUT + 2, 3'b110, '0, 0);
        idle(2);

        // Random traffic, biased toward long stalls so timeouts occur.
        for (int k = 0; k < 1500; k++) begin
            logic [NP-1:0] rd, em;
            for (int i = 0; i < NP; i++) begin
                rd[i] = ($urandom_range(0, 15) == 0);
                em[i] = ($urandom_range(0, 5) == 0);
            end
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                 AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 rd, NP'($urandom_range(0, 7)), em, ($urandom_range(0, 39) == 0));
        end

        repeat (3) @(negedge clock);
        #5;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
